// File: rtl/fetch_stall_ctrl.sv
// Front-end PC / IF-ID / ID-EX bubble owner; 1-cycle register latency, HALT drains DRAIN_CYCLES edges.
// No valid-ready handshake: hazard unit stalls hold PC/IF-ID, enable_i=0 freezes all state.
module fetch_stall_ctrl #(
   parameter int NB_PC        = 32,
   parameter int NB_INSTR     = 32,
   parameter int NB_CTRL      = 9,
   parameter int DRAIN_CYCLES = 4,
   parameter int NB_CNT       = 16
) (
   input  logic                clock_i,
   input  logic                reset_n_i,
   input  logic                enable_i,
   input  logic                pc_write_i,
   input  logic                IF_ID_write_i,
   input  logic                stall_i,
   input  logic                halt_i,
   input  logic                branch_taken_i,
   input  logic [NB_PC-1:0]    branch_target_i,
   input  logic [NB_INSTR-1:0] instruction_i,
   input  logic [NB_CTRL-1:0]  ID_ctrl_i,
   output logic [NB_PC-1:0]    pc_o,
   output logic [NB_PC-1:0]    IF_ID_pc_next_o,
   output logic [NB_INSTR-1:0] IF_ID_instruction_o,
   output logic [NB_CTRL-1:0]  ID_EX_ctrl_o,
   output logic                halted_o,
   output logic [NB_CNT-1:0]   stall_count_o
);

   localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

   state_t              state_q, state_d;
   logic [NB_DRAIN-1:0] drain_q, drain_d;
   logic [NB_PC-1:0]    pc_q, pc_d;
   logic [NB_PC-1:0]    ifid_pc_next_q, ifid_pc_next_d;
   logic [NB_INSTR-1:0] ifid_instr_q, ifid_instr_d;
   logic [NB_CTRL-1:0]  idex_ctrl_q, idex_ctrl_d;
   logic                halted_q, halted_d;
   logic [NB_CNT-1:0]   stall_cnt_q, stall_cnt_d;

   logic             run;
   logic             hold_front;
   logic             br;
   logic [NB_PC-1:0] pc_plus4;

   assign run        = (state_q == ST_RUN);
   // A HALT sampled in RUN freezes the front end on that same edge, discarding any branch.
   assign hold_front = ~run | halt_i;
   assign br         = branch_taken_i & ~stall_i;
   assign pc_plus4   = pc_q + NB_PC'(4);

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         ST_RUN: begin
            if (halt_i) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (drain_q == '0) state_d = ST_HALTED;
            else               drain_d = drain_q - NB_DRAIN'(1);
         end
         default: state_d = ST_HALTED;
      endcase
   end

   always_comb begin
      pc_d           = pc_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_pc_next_d = ifid_pc_next_q;
      stall_cnt_d    = stall_cnt_q;

      if (!hold_front && pc_write_i) begin
         pc_d = br ? branch_target_i : pc_plus4;
      end

      if (!hold_front && IF_ID_write_i) begin
         if (br) begin
            ifid_instr_d   = '0;
            ifid_pc_next_d = '0;
         end else begin
            ifid_instr_d   = instruction_i;
            ifid_pc_next_d = pc_plus4;
         end
      end

      idex_ctrl_d = (stall_i || halt_i || !run) ? '0 : ID_ctrl_i;

      if (run && stall_i && !halt_i && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + NB_CNT'(1);
      end

      halted_d = halted_q | (state_d == ST_HALTED);
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q        <= ST_RUN;
         drain_q        <= '0;
         pc_q           <= '0;
         ifid_pc_next_q <= '0;
         ifid_instr_q   <= '0;
         idex_ctrl_q    <= '0;
         halted_q       <= 1'b0;
         stall_cnt_q    <= '0;
      end else if (enable_i) begin
         state_q        <= state_d;
         drain_q        <= drain_d;
         pc_q           <= pc_d;
         ifid_pc_next_q <= ifid_pc_next_d;
         ifid_instr_q   <= ifid_instr_d;
         idex_ctrl_q    <= idex_ctrl_d;
         halted_q       <= halted_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign pc_o                = pc_q;
   assign IF_ID_pc_next_o     = ifid_pc_next_q;
   assign IF_ID_instruction_o = ifid_instr_q;
   assign ID_EX_ctrl_o        = idex_ctrl_q;
   assign halted_o            = halted_q;
   assign stall_count_o       = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: expectations queued per step, popped after the edge.
module tb_fetch_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable;
   logic        pc_write;
   logic        if_id_write;
   logic        stall;
   logic        halt;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] instr;
   logic [8:0]  id_ctrl;
   logic [31:0] pc;
   logic [31:0] ifid_pc_next;
   logic [31:0] ifid_instr;
   logic [8:0]  idex_ctrl;
   logic        halted;
   logic [15:0] stall_count;

   int checks = 0;
   int errors = 0;

   fetch_stall_ctrl #(
      .NB_PC(32), .NB_INSTR(32), .NB_CTRL(9), .DRAIN_CYCLES(4), .NB_CNT(16)
   ) dut (
      .clock_i             (clk),
      .reset_n_i           (rst_n),
      .enable_i            (enable),
      .pc_write_i          (pc_write),
      .IF_ID_write_i       (if_id_write),
      .stall_i             (stall),
      .halt_i              (halt),
      .branch_taken_i      (br_taken),
      .branch_target_i     (br_target),
      .instruction_i       (instr),
      .ID_ctrl_i           (id_ctrl),
      .pc_o                (pc),
      .IF_ID_pc_next_o     (ifid_pc_next),
      .IF_ID_instruction_o (ifid_instr),
      .ID_EX_ctrl_o        (idex_ctrl),
      .halted_o            (halted),
      .stall_count_o       (stall_count)
   );

   always #5 clk = ~clk;

   typedef enum int {S_PC, S_IFPC, S_IFIN, S_CTRL, S_HALT, S_CNT} sig_e;
   typedef struct {
      sig_e        sig;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];

   task automatic push(input sig_e s, input logic [31:0] e, input string t);
      exp_t x;
      x.sig = s;
      x.exp = e;
      x.tag = t;
      sb.push_back(x);
   endtask

   task automatic push_front_end(input logic [31:0] p, input logic [31:0] ip,
                                 input logic [31:0] ii, input string t);
      push(S_PC, p, {t, "_pc"});
      push(S_IFPC, ip, {t, "_ifid_pc_next"});
      push(S_IFIN, ii, {t, "_ifid_instr"});
   endtask

   function automatic logic [31:0] observe(input sig_e s);
      case (s)
         S_PC:    return pc;
         S_IFPC:  return ifid_pc_next;
         S_IFIN:  return ifid_instr;
         S_CTRL:  return {23'd0, idex_ctrl};
         S_HALT:  return {31'd0, halted};
         default: return {16'd0, stall_count};
      endcase
   endfunction

   task automatic check_sb();
      exp_t        x;
      logic [31:0] o;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         o = observe(x.sig);
         checks++;
         assert (o === x.exp)
         else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_sb();
   endtask

   task automatic push_all_zero(input string t);
      push_front_end(32'h0, 32'h0, 32'h0, t);
      push(S_CTRL, 32'h0, {t, "_ctrl"});
      push(S_HALT, 32'h0, {t, "_halted"});
      push(S_CNT, 32'h0, {t, "_cnt"});
   endtask

   localparam logic [31:0] ADDI = 32'h2008_0005;

   initial begin
      enable = 1'b1; pc_write = 1'b1; if_id_write = 1'b1; stall = 1'b0; halt = 1'b0;
      br_taken = 1'b0; br_target = 32'h0; instr = ADDI; id_ctrl = 9'h0;

      #1 rst_n = 1'b0;
      #2;
      push_all_zero("reset");
      check_sb();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Plain fetch: PC advances by 4, ID/EX control lags ID_ctrl_i by one edge.
      id_ctrl = 9'h011;
      push_front_end(32'h4, 32'h4, ADDI, "run1");
      push(S_CTRL, 32'h011, "run1_ctrl");
      tick();
      id_ctrl = 9'h022;
      push_front_end(32'h8, 32'h8, ADDI, "run2");
      push(S_CTRL, 32'h022, "run2_ctrl");
      tick();
      id_ctrl = 9'h033;
      push_front_end(32'hC, 32'hC, ADDI, "run3");
      push(S_CTRL, 32'h033, "run3_ctrl");
      tick();
      id_ctrl = 9'h044;
      push_front_end(32'h10, 32'h10, ADDI, "run4");
      tick();

      // Load-use stall with a concurrent taken branch: stall wins.
      pc_write = 1'b0; if_id_write = 1'b0; stall = 1'b1;
      br_taken = 1'b1; br_target = 32'h80; instr = 32'h1234_5678;
      push_front_end(32'h10, 32'h10, ADDI, "stall");
      push(S_CTRL, 32'h0, "stall_ctrl");
      push(S_CNT, 32'h1, "stall_cnt");
      tick();

      pc_write = 1'b1; if_id_write = 1'b1; stall = 1'b0; br_taken = 1'b0;
      instr = ADDI; id_ctrl = 9'h055;
      push_front_end(32'h14, 32'h14, ADDI, "unstall");
      push(S_CTRL, 32'h055, "unstall_ctrl");
      push(S_CNT, 32'h1, "unstall_cnt");
      tick();

      br_taken = 1'b1; br_target = 32'h40;
      push_front_end(32'h40, 32'h0, 32'h0, "branch");
      tick();
      br_taken = 1'b0;
      push_front_end(32'h44, 32'h44, ADDI, "post_branch");
      tick();

      // Hazard enables that disagree act independently.
      pc_write = 1'b0; instr = 32'hAAAA_0001;
      push_front_end(32'h44, 32'h48, 32'hAAAA_0001, "split_en");
      tick();

      pc_write = 1'b1; enable = 1'b0; stall = 1'b1; id_ctrl = 9'h1FF; br_taken = 1'b1;
      push_front_end(32'h44, 32'h48, 32'hAAAA_0001, "frozen");
      push(S_CTRL, 32'h055, "frozen_ctrl");
      push(S_CNT, 32'h1, "frozen_cnt");
      tick();

      // HALT together with a taken branch: halt wins, front end holds.
      enable = 1'b1; stall = 1'b0; halt = 1'b1; br_target = 32'h300; id_ctrl = 9'h055;
      instr = ADDI;
      push_front_end(32'h44, 32'h48, 32'hAAAA_0001, "halt_N");
      push(S_CTRL, 32'h0, "halt_N_ctrl");
      push(S_HALT, 32'h0, "halt_N_halted");
      tick();

      halt = 1'b0; br_taken = 1'b0; stall = 1'b1; enable = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         push(S_HALT, 32'h0, $sformatf("drain_off%0d_halted", i));
         tick();
      end
      enable = 1'b1;
      for (int i = 3; i <= 5; i++) begin
         push(S_HALT, 32'h0, $sformatf("drain%0d_halted", i));
         push(S_PC, 32'h44, $sformatf("drain%0d_pc", i));
         push(S_CNT, 32'h1, $sformatf("drain%0d_cnt", i));
         push(S_CTRL, 32'h0, $sformatf("drain%0d_ctrl", i));
         tick();
      end
      push(S_HALT, 32'h1, "drain6_halted");
      tick();
      stall = 1'b0; halt = 1'b1;
      for (int i = 0; i < 2; i++) begin
         push(S_HALT, 32'h1, $sformatf("sticky%0d_halted", i));
         push(S_CTRL, 32'h0, $sformatf("sticky%0d_ctrl", i));
         push(S_PC, 32'h44, $sformatf("sticky%0d_pc", i));
         tick();
      end
      halt = 1'b0;

      #3 rst_n = 1'b0;
      #1;
      push_all_zero("rst_halted");
      check_sb();
      rst_n = 1'b1;
      push_front_end(32'h4, 32'h4, ADDI, "restart");
      push(S_HALT, 32'h0, "restart_halted");
      tick();

      // Async reset landing between edges while draining.
      halt = 1'b1;
      push(S_PC, 32'h4, "halt2_pc");
      tick();
      halt = 1'b0;
      push(S_HALT, 32'h0, "halt2_d1_halted");
      tick();
      #3 rst_n = 1'b0;
      #1;
      push_all_zero("rst_drain");
      check_sb();
      rst_n = 1'b1;
      push_front_end(32'h4, 32'h4, ADDI, "resume");
      push(S_HALT, 32'h0, "resume_halted");
      tick();
      push(S_PC, 32'h8, "resume2_pc");
      tick();

      // PC wrap at the top of the address space.
      br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
      push_front_end(32'hFFFF_FFFC, 32'h0, 32'h0, "to_top");
      tick();
      br_taken = 1'b0;
      push_front_end(32'h0, 32'h0, ADDI, "wrap");
      tick();

      // Long stall saturates the counter.
      pc_write = 1'b0; if_id_write = 1'b0; stall = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      push(S_CNT, 32'hFFFF, "sat_cnt");
      push(S_PC, 32'h0, "sat_pc");
      push(S_CTRL, 32'h0, "sat_ctrl");
      check_sb();
      push(S_CNT, 32'hFFFF, "sat_hold_cnt");
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
